// File: rtl/spi_rx_pkg.sv
// Shared types and constants for the SPI slave byte receiver.
package spi_rx_pkg;

  localparam int BYTE_W                  = 8;
  localparam int IDX_W                   = 4;
  localparam int BIT_CNT_W               = 3;
  localparam int DEFAULT_MAX_FRAME_BYTES = 9;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ACTIVE   = 2'd1,
    ST_OVERFLOW = 2'd2
  } rx_state_e;

  function automatic logic [IDX_W-1:0] sat_inc(input logic [IDX_W-1:0] value,
                                               input logic [IDX_W-1:0] limit);
    return (value >= limit) ? value : value + IDX_W'(1);
  endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for one asynchronous input; rise/fall pulses come
// from the last stage compared against one extra registered copy.
module spi_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_chain;
  logic                   r_prev;

  // NOTE: clocked state uses non-blocking assignments so every stage samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain <= {SYNC_STAGES{RESET_VAL}};
      r_prev  <= RESET_VAL;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
      r_prev  <= r_chain[SYNC_STAGES-1];
    end
  end

  assign o_sync = r_chain[SYNC_STAGES-1];
  assign o_rise =  o_sync & ~r_prev;
  assign o_fall = ~o_sync &  r_prev;

endmodule

// File: rtl/spi_slave_byte_rx.sv
// SPI mode-0 slave byte receiver: oversamples SCK/CS_n/MOSI in sysClk, builds
// MSB-first bytes, flags frame boundaries/errors. Define SPI_SLAVE_TX_EN for MISO.
module spi_slave_byte_rx
  import spi_rx_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int MAX_FRAME_BYTES = DEFAULT_MAX_FRAME_BYTES
) (
  input  logic              sysClk,
  input  logic              reset_n,
  input  logic              spi_sck,
  input  logic              spi_cs_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [BYTE_W-1:0] spi_byte,
  output logic              spi_input_valid,
  output logic [IDX_W-1:0]  byte_index,
  output logic              frame_start,
  output logic              frame_end,
  output logic              frame_error,
  input  logic [BYTE_W-1:0] tx_byte,
  input  logic              tx_load,
  output logic              tx_ready
);

  localparam logic [IDX_W-1:0]     MAX_BYTES  = IDX_W'(MAX_FRAME_BYTES);
  localparam logic [2:0]           SETTLE_CYC = 3'(SYNC_STAGES + 1);
  localparam logic [BIT_CNT_W-1:0] LAST_BIT   = '1;

  logic w_sck_s_unused, w_sck_rise_raw, w_sck_fall_raw;
  logic w_cs_s_unused,  w_cs_rise_raw,  w_cs_fall_raw;
  logic w_mosi_s, w_mosi_rise_unused, w_mosi_fall_unused;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk(sysClk), .rst_n(reset_n), .i_async(spi_sck),
    .o_sync(w_sck_s_unused), .o_rise(w_sck_rise_raw), .o_fall(w_sck_fall_raw)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(sysClk), .rst_n(reset_n), .i_async(spi_cs_n),
    .o_sync(w_cs_s_unused), .o_rise(w_cs_rise_raw), .o_fall(w_cs_fall_raw)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(sysClk), .rst_n(reset_n), .i_async(spi_mosi),
    .o_sync(w_mosi_s), .o_rise(w_mosi_rise_unused), .o_fall(w_mosi_fall_unused)
  );

  // Edge pulses are ignored until the chains have flushed their reset values,
  // so a CS_n already low at reset release never looks like a fresh fall.
  logic [2:0] r_settle;
  logic       w_settled;

  always_ff @(posedge sysClk or negedge reset_n) begin
    if (!reset_n)                   r_settle <= '0;
    else if (r_settle != SETTLE_CYC) r_settle <= r_settle + 3'd1;
  end

  assign w_settled = (r_settle == SETTLE_CYC);

  logic w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall;
  assign w_sck_rise = w_sck_rise_raw & w_settled;
  assign w_sck_fall = w_sck_fall_raw & w_settled;
  assign w_cs_rise  = w_cs_rise_raw  & w_settled;
  assign w_cs_fall  = w_cs_fall_raw  & w_settled;

  rx_state_e            r_state,     w_state_nxt;
  logic [BIT_CNT_W-1:0] r_bit_cnt,   w_bit_cnt_nxt;
  logic [BYTE_W-1:0]    r_shift,     w_shift_nxt;
  logic [IDX_W-1:0]     r_byte_cnt,  w_byte_cnt_nxt;
  logic [IDX_W-1:0]     r_done_idx,  w_done_idx_nxt;
  logic                 r_byte_done, w_byte_done_nxt;
  logic                 r_end_pend,  w_end_pend_nxt;
  logic                 w_start_nxt, w_end_nxt, w_err_nxt;

  always_ff @(posedge sysClk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_byte_cnt  <= '0;
      r_done_idx  <= '0;
      r_byte_done <= 1'b0;
      r_end_pend  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_byte_cnt  <= w_byte_cnt_nxt;
      r_done_idx  <= w_done_idx_nxt;
      r_byte_done <= w_byte_done_nxt;
      r_end_pend  <= w_end_pend_nxt;
    end
  end

  // NOTE: every signal driven here is given a default first; any path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_shift_nxt     = r_shift;
    w_byte_cnt_nxt  = r_byte_cnt;
    w_done_idx_nxt  = r_done_idx;
    w_byte_done_nxt = 1'b0;
    w_end_pend_nxt  = r_end_pend;
    w_start_nxt     = 1'b0;
    w_end_nxt       = 1'b0;
    w_err_nxt       = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (w_cs_fall) begin
          w_start_nxt    = 1'b1;
          w_bit_cnt_nxt  = '0;
          w_byte_cnt_nxt = '0;
          w_shift_nxt    = '0;
          w_end_pend_nxt = 1'b0;
          w_state_nxt    = ST_ACTIVE;
        end
      end

      ST_ACTIVE: begin
        if (r_end_pend) begin
          // Deferred close: wait until the final byte has been strobed.
          if (!r_byte_done) begin
            w_end_nxt      = 1'b1;
            w_end_pend_nxt = 1'b0;
            w_state_nxt    = ST_IDLE;
          end
        end else begin
          if (w_sck_rise) begin
            if (r_byte_cnt == MAX_BYTES) begin
              w_state_nxt = ST_OVERFLOW;
            end else begin
              w_shift_nxt   = {r_shift[BYTE_W-2:0], w_mosi_s};
              w_bit_cnt_nxt = r_bit_cnt + BIT_CNT_W'(1);
              if (r_bit_cnt == LAST_BIT) begin
                w_byte_done_nxt = 1'b1;
                w_done_idx_nxt  = r_byte_cnt;
                w_byte_cnt_nxt  = sat_inc(r_byte_cnt, MAX_BYTES);
              end
            end
          end
          if (w_cs_rise) begin
            if (w_byte_done_nxt) begin
              w_end_pend_nxt = 1'b1;
            end else begin
              w_end_nxt     = 1'b1;
              w_err_nxt     = (w_bit_cnt_nxt != '0) || (w_state_nxt == ST_OVERFLOW);
              w_bit_cnt_nxt = '0;
              w_state_nxt   = ST_IDLE;
            end
          end
        end
      end

      ST_OVERFLOW: begin
        if (w_cs_rise) begin
          w_end_nxt     = 1'b1;
          w_err_nxt     = 1'b1;
          w_bit_cnt_nxt = '0;
          w_state_nxt   = ST_IDLE;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysClk or negedge reset_n) begin
    if (!reset_n) begin
      spi_byte        <= '0;
      spi_input_valid <= 1'b0;
      byte_index      <= '0;
      frame_start     <= 1'b0;
      frame_end       <= 1'b0;
      frame_error     <= 1'b0;
    end else begin
      spi_input_valid <= r_byte_done;
      if (r_byte_done) begin
        spi_byte   <= r_shift;
        byte_index <= r_done_idx;
      end
      frame_start <= w_start_nxt;
      frame_end   <= w_end_nxt;
      frame_error <= w_err_nxt;
    end
  end

`ifdef SPI_SLAVE_TX_EN
  logic [BYTE_W-1:0]    r_tx_hold;
  logic [BYTE_W-1:0]    r_tx_shift;
  logic [BIT_CNT_W-1:0] r_tx_bits;
  logic                 r_tx_full;
  logic                 w_tx_accept, w_tx_xfer, w_tx_leave;

  assign w_tx_accept = tx_load && !r_tx_full;
  // Byte boundaries: frame start, and the 8th SCK fall of every byte.
  assign w_tx_xfer   = ((r_state == ST_IDLE) && w_cs_fall) ||
                       ((r_state == ST_ACTIVE) && w_sck_fall && (r_tx_bits == LAST_BIT));
  assign w_tx_leave  = (r_state != ST_IDLE) && (w_state_nxt == ST_IDLE);

  always_ff @(posedge sysClk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_hold  <= '0;
      r_tx_shift <= '0;
      r_tx_bits  <= '0;
      r_tx_full  <= 1'b0;
    end else begin
      if (w_tx_accept) r_tx_hold <= tx_byte;

      if (w_tx_accept)    r_tx_full <= 1'b1;
      else if (w_tx_xfer) r_tx_full <= 1'b0;

      if (w_tx_leave) begin
        r_tx_shift <= '0;
        r_tx_bits  <= '0;
      end else if (w_tx_xfer) begin
        r_tx_shift <= r_tx_full ? r_tx_hold : '0;
        r_tx_bits  <= '0;
      end else if ((r_state == ST_ACTIVE) && w_sck_fall) begin
        r_tx_shift <= {r_tx_shift[BYTE_W-2:0], 1'b0};
        r_tx_bits  <= r_tx_bits + BIT_CNT_W'(1);
      end
    end
  end

  assign spi_miso = r_tx_shift[BYTE_W-1];
  assign tx_ready = ~r_tx_full;
`else
  logic w_tx_unused;
  assign w_tx_unused = ^{tx_byte, tx_load, w_sck_fall};
  assign spi_miso    = 1'b0;
  assign tx_ready    = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_byte_rx.sv
// Self-checking bench for spi_slave_byte_rx: a frame-level model predicts
// strobes, indices and errors; a negedge monitor compares every cycle.
module tb_spi_slave_byte_rx;

`ifdef SPI_SLAVE_TX_EN
  localparam bit TX_EN = 1'b1;
`else
  localparam bit TX_EN = 1'b0;
`endif
  localparam int CLK_HALF  = 5;
  localparam int SCK_HALF  = 40;
  localparam int MAX_BYTES = 9;

  logic       sysClk   = 1'b0;
  logic       reset_n  = 1'b0;
  logic       spi_sck  = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_mosi = 1'b0;
  logic [7:0] tx_byte  = 8'h00;
  logic       tx_load  = 1'b0;
  logic       spi_miso, spi_input_valid, frame_start, frame_end, frame_error, tx_ready;
  logic [7:0] spi_byte;
  logic [3:0] byte_index;

  spi_slave_byte_rx dut (
    .sysClk(sysClk), .reset_n(reset_n), .spi_sck(spi_sck), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_byte(spi_byte),
    .spi_input_valid(spi_input_valid), .byte_index(byte_index),
    .frame_start(frame_start), .frame_end(frame_end), .frame_error(frame_error),
    .tx_byte(tx_byte), .tx_load(tx_load), .tx_ready(tx_ready)
  );

  always #CLK_HALF sysClk = ~sysClk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_starts = 0, n_ends = 0, n_strobes = 0;
  int exp_starts = 0, exp_ends = 0, exp_strobes = 0;

  logic [11:0] exp_q[$];
  logic        exp_err_q[$];
  logic [7:0]  mosi_q[$];
  logic [79:0] miso_cap = '0;
  logic [11:0] mon_exp;
  logic        mon_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  // Frame-level model: whole bytes up to the frame limit are strobed in order;
  // a trailing partial byte or any bit beyond the limit flags an error.
  task automatic model_frame(input int nbits);
    int nbytes;
    nbytes = nbits / 8;
    if (nbytes > MAX_BYTES) nbytes = MAX_BYTES;
    for (int k = 0; k < nbytes; k++) exp_q.push_back({4'(k), mosi_q[k]});
    exp_err_q.push_back((nbits % 8 != 0) || (nbits > MAX_BYTES * 8));
    exp_starts++;
    exp_ends++;
    exp_strobes += nbytes;
  endtask

  task automatic drive_bits(input int first, input int nbits);
    for (int i = first; i < first + nbits; i++) begin
      spi_mosi = mosi_q[i / 8][7 - (i % 8)];
      #SCK_HALF;
      spi_sck = 1'b1;
      #(SCK_HALF / 2);
      miso_cap = {miso_cap[78:0], spi_miso};
      #(SCK_HALF / 2);
      spi_sck = 1'b0;
    end
  endtask

  task automatic run_frame(input int nbits);
    model_frame(nbits);
    spi_cs_n = 1'b0;
    #SCK_HALF;
    drive_bits(0, nbits);
    #SCK_HALF;
    spi_cs_n = 1'b1;
    #(6 * SCK_HALF);
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_starts"},  32'(n_starts),       32'(exp_starts));
    check({tag, "_ends"},    32'(n_ends),         32'(exp_ends));
    check({tag, "_strobes"}, 32'(n_strobes),      32'(exp_strobes));
    check({tag, "_pending"}, 32'(exp_q.size()),   32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_outputs"}, 32'({spi_input_valid, frame_start, frame_end, frame_error,
                                  spi_miso, byte_index, spi_byte}), 32'd0);
    check({tag, "_tx_ready"}, 32'(tx_ready), 32'(TX_EN));
  endtask

  always @(negedge sysClk) begin
    if (frame_start) n_starts++;
    if (spi_input_valid) begin
      n_strobes++;
      check("strobe_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        check("spi_byte",   32'(spi_byte),   32'(mon_exp[7:0]));
        check("byte_index", 32'(byte_index), 32'(mon_exp[11:8]));
      end
    end
    if (frame_end || frame_error) begin
      check("error_with_end", 32'(frame_end), 32'd1);
      if (frame_end) n_ends++;
      check("end_expected", 32'(exp_err_q.size() != 0), 32'd1);
      if (exp_err_q.size() != 0) begin
        mon_err = exp_err_q.pop_front();
        check("frame_error", 32'(frame_error), 32'(mon_err));
      end
    end
  end

  initial begin
    repeat (3) @(negedge sysClk);
    check_reset_outputs("por");
    reset_n = 1'b1;
    repeat (5) @(negedge sysClk);

    mosi_q = '{8'hA1, 8'h8E, 8'hFE, 8'h6F, 8'hA6, 8'h36, 8'h1A, 8'hAA, 8'h55};
    run_frame(72);
    check_counts("nine_bytes");
    check("nine_last_byte",  32'(spi_byte),   32'h55);
    check("nine_last_index", 32'(byte_index), 32'd8);

    mosi_q = '{8'h5A, 8'hF0};
    run_frame(12);
    check_counts("partial");
    check("partial_held_byte", 32'(spi_byte),   32'h5A);
    check("partial_index",     32'(byte_index), 32'd0);

    mosi_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
    run_frame(80);
    check_counts("overflow");
    check("overflow_held_byte", 32'(spi_byte),   32'h09);
    check("overflow_index",     32'(byte_index), 32'd8);

    for (int i = 0; i < 16; i++) begin
      spi_mosi = i[0];
      #SCK_HALF;
      spi_sck = ~spi_sck;
    end
    spi_sck = 1'b0;
    #(6 * SCK_HALF);
    check_counts("idle_sck");

    mosi_q = '{8'h12, 8'h34, 8'hC7};
    exp_q.push_back({4'd0, 8'h12});
    exp_q.push_back({4'd1, 8'h34});
    exp_starts++;
    exp_strobes += 2;
    spi_cs_n = 1'b0;
    #SCK_HALF;
    drive_bits(0, 21);
    @(negedge sysClk);
    reset_n = 1'b0;
    repeat (3) @(negedge sysClk);
    check_reset_outputs("mid_reset");
    reset_n = 1'b1;
    drive_bits(21, 3);
    #(4 * SCK_HALF);
    check("after_reset_byte", 32'(spi_byte), 32'd0);
    check_counts("reset_held_low");
    spi_cs_n = 1'b1;
    #(6 * SCK_HALF);
    check_counts("reset_cs_release");
    mosi_q = '{8'h3C};
    run_frame(8);
    check_counts("post_reset");
    check("post_reset_byte",  32'(spi_byte),   32'h3C);
    check("post_reset_index", 32'(byte_index), 32'd0);

    mosi_q = '{8'h81, 8'h42};
    check("tx_ready_idle", 32'(tx_ready), 32'(TX_EN));
    @(negedge sysClk);
    tx_byte = 8'hC3;
    tx_load = 1'b1;
    @(negedge sysClk);
    tx_load = 1'b0;
    tx_byte = 8'h00;
    check("tx_ready_loaded", 32'(tx_ready), 32'd0);
    miso_cap = '0;
    run_frame(16);
    check("miso_stream", 32'(miso_cap[15:0]), TX_EN ? 32'hC300 : 32'h0000);
    check("tx_ready_after", 32'(tx_ready), 32'(TX_EN));
    check_counts("tx_frame");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
